interrupt_arbiter: RTL and testbench
====================================

# interrupt_arbiter

Upstream stage of `interrupt_controller` in the 64-bit single-cycle RISC-V core. It collects `NUM_SRC` external interrupt lines and latches rising edges as pending bits. It applies a per-source mask and selects the highest-priority pending source (lowest index wins). It then drives a single `interrupt_request` with a stable `irq_id` and holds it until the controller acknowledges. After the acknowledge it blocks further requests until the handler signals completion (`irq_complete`, driven by the core on `mret`).

## Interface
Parameters:
- `NUM_SRC`, 8: number of interrupt sources, 2..32.
- `ID_W`, `$clog2(NUM_SRC)`: width of `irq_id`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `irq_src`  in  NUM_SRC  raw interrupt lines; a rising edge raises an interrupt.
- `irq_mask`  in  NUM_SRC  1 = source enabled for arbitration. Masked sources still latch pending.
- `interrupt_acknowledge`  in  1  from `interrupt_controller`; consumed only in REQUEST.
- `irq_complete`  in  1  single-cycle pulse at handler exit; consumed only in IN_SERVICE.
- `interrupt_request`  out  1  to `interrupt_controller`.
- `irq_id`  out  ID_W  index of the requested or in-service source.
- `irq_pending`  out  NUM_SRC  current pending register, for CSR readback.
- `in_service`  out  1  high while in IN_SERVICE.

## Operation
- Edge detect: `rise[i] = s[i] & ~s_d[i]`, where `s` is the sampled source and `s_d` its one-cycle delay. `rise[i]` sets `pending[i]`.
- Pending clear: `pending[irq_id]` clears on the cycle the acknowledge is accepted.
- Set/clear collision: if set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Eligibility: `elig = pending & irq_mask`. Fixed priority, bit 0 highest.
- FSM states: IDLE, REQUEST, IN_SERVICE.
  - IDLE: if `elig != 0`, latch `irq_id` = lowest set index of `elig` and go to REQUEST. Otherwise stay.
  - REQUEST: `interrupt_request = 1`. `irq_id` is frozen even if the mask changes or a higher-priority source rises. On `interrupt_acknowledge = 1`, clear `pending[irq_id]` and go to IN_SERVICE.
  - IN_SERVICE: `interrupt_request = 0`, `in_service = 1`, `irq_id` held. On `irq_complete = 1`, go to IDLE. There is no nesting.
- Stray inputs: `interrupt_acknowledge` outside REQUEST and `irq_complete` outside IN_SERVICE are ignored.
- `interrupt_request` is a registered output: high exactly when the state is REQUEST.

## Timing
- Reset values:
  - state IDLE
  - `interrupt_request = 0`
  - `irq_id = 0`
  - `irq_pending = 0`
  - `in_service = 0`
  - all sample and delay flops 0
- Reset asserted mid-operation returns to these values immediately (asynchronous). A source already high when reset releases is not a rising edge and is not latched.
- Without sync, a source rising before edge E0:
  - `pending[i] = 1` after E0
  - `interrupt_request = 1` after E1
- Ack loop with `interrupt_controller`:
  - controller sees the request at E2 and drives ack high after E2
  - arbiter accepts the ack at E3: request low, pending bit cleared, state IN_SERVICE
  - the controller's ack stays high through E3; the arbiter ignores it in IN_SERVICE
- `irq_complete` at edge Ec gives IDLE after Ec. A waiting eligible source raises `interrupt_request` after Ec+1.
- Minimum spacing between back-to-back serviced interrupts: 3 cycles from acknowledge to the next request, given an immediate `irq_complete`.

## Configuration
- `IRQ_ARB_SYNC_EN`
  - Defined: each `irq_src` bit passes through a 2-flop synchronizer before edge detection, which adds 2 cycles of latency (pending after E2, request after E3). Required when sources are asynchronous peripherals.
  - Undefined: `irq_src` is sampled directly by the edge-detect flop. Sources must be synchronous to `clk`.

## Test plan
- Single source (sync off): `irq_src = 8'h04` rises before E0 -> `irq_pending = 8'h04` after E0, `interrupt_request = 1` and `irq_id = 2` after E1. Ack at E3 -> request 0, `irq_pending = 0`, `in_service = 1`.
- Priority plus mask change: sources 1, 5 and 6 rise together with `irq_mask = 8'hFF` -> `irq_id = 1`. Clearing `mask[1]` during REQUEST keeps `irq_id = 1`. After complete, the next request has `irq_id = 5`, then `irq_id = 6`.
- Masked latch: source 3 rises with `mask[3] = 0` -> pending set, no request. Setting `mask[3] = 1` -> request with `irq_id = 3` one cycle later.
- Collision: source 4 re-rises on the exact acknowledge cycle of `irq_id = 4` -> `pending[4]` stays 1. After `irq_complete`, a second request for id 4 is issued.
- Stray handshake and reset: an ack pulse in IDLE and an `irq_complete` pulse in REQUEST produce no state change. `reset_n` low in IN_SERVICE -> all outputs 0 immediately. A source held high across reset release is not requested.
- With `IRQ_ARB_SYNC_EN` defined: rise before E0 -> `interrupt_request = 1` after E3. A 1-cycle glitch-free pulse is still latched.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - edge-latched, masked, fixed-priority interrupt arbiter with ack/complete handshake
// Optional: IRQ_ARB_SYNC_EN adds a 2-flop synchronizer on every irq_src bit.
module interrupt_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               interrupt_acknowledge,
  input  logic               irq_complete,
  output logic               interrupt_request,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               in_service
);

  typedef enum logic [1:0] {IDLE, REQUEST, IN_SERVICE} state_t;

  state_t             state_q, state_n;
  logic [ID_W-1:0]    id_q, id_n;
  logic [NUM_SRC-1:0] pending_q, pending_n;
  logic [NUM_SRC-1:0] s, s_d, rise, elig, clr;
  logic [ID_W-1:0]    lowest_id;
  logic               req_q, svc_q;
  logic [1:0]         arm_cnt;
  logic               armed;

`ifdef IRQ_ARB_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign s = irq_src;
`endif

  // Edge detection stays disarmed until s_d holds a real sample, so a line
  // already high at reset release is not mistaken for a rising edge.
  assign armed = (arm_cnt == ARM_CYC);
  assign rise  = armed ? (s & ~s_d) : '0;
  assign elig  = pending_q & irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_d     <= '0;
      arm_cnt <= 2'd0;
    end else begin
      s_d <= s;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  always_comb begin
    lowest_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) lowest_id = ID_W'(i);
    end
  end

  always_comb begin
    state_n = state_q;
    id_n    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (elig != '0) begin
          id_n    = lowest_id;
          state_n = REQUEST;
        end
      end
      REQUEST: begin
        if (interrupt_acknowledge) begin
          clr     = {{(NUM_SRC-1){1'b0}}, 1'b1} << id_q;
          state_n = IN_SERVICE;
        end
      end
      IN_SERVICE: begin
        if (irq_complete) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A new edge on the bit being acknowledged wins over the clear.
    pending_n = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      pending_q <= '0;
      req_q     <= 1'b0;
      svc_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      id_q      <= id_n;
      pending_q <= pending_n;
      req_q     <= (state_n == REQUEST);
      svc_q     <= (state_n == IN_SERVICE);
    end
  end

  assign interrupt_request = req_q;
  assign in_service        = svc_q;
  assign irq_id            = id_q;
  assign irq_pending       = pending_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - randomized + directed self-checking bench for interrupt_arbiter
module tb_interrupt_arbiter;
  localparam int N = 8;
`ifdef IRQ_ARB_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic [N-1:0] irq_mask = '1;
  logic         interrupt_acknowledge = 1'b0;
  logic         irq_complete = 1'b0;
  logic         interrupt_request;
  logic [2:0]   irq_id;
  logic [N-1:0] irq_pending;
  logic         in_service;

  int n_tests = 0;
  int n_fail  = 0;

  interrupt_arbiter #(.NUM_SRC(N)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .irq_src               (irq_src),
    .irq_mask              (irq_mask),
    .interrupt_acknowledge (interrupt_acknowledge),
    .irq_complete          (irq_complete),
    .interrupt_request     (interrupt_request),
    .irq_id                (irq_id),
    .irq_pending           (irq_pending),
    .in_service            (in_service)
  );

  always #5 clk = ~clk;

  // Reference: history of raw source samples, pending set, and a 3-phase handshake.
  logic [N-1:0] hist [0:3];
  logic [N-1:0] m_pend;
  int           m_phase;   // 0 idle, 1 requesting, 2 servicing
  int           m_id;
  int           m_edges;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [N-1:0] new_hist(input int j);
    return (j == 0) ? irq_src : hist[j-1];
  endfunction

  function automatic logic [N-1:0] m_rise();
    if (m_edges < LAT + 1) return '0;
    return new_hist(LAT) & ~new_hist(LAT + 1);
  endfunction

  function automatic logic [N-1:0] m_clear();
    logic [N-1:0] c;
    c = '0;
    if (m_phase == 1 && interrupt_acknowledge) c[m_id] = 1'b1;
    return c;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < 4; j++) hist[j] <= '0;
      m_pend  <= '0;
      m_phase <= 0;
      m_id    <= 0;
      m_edges <= 0;
    end else begin
      for (int j = 0; j < 4; j++) hist[j] <= new_hist(j);
      m_edges <= (m_edges < 100) ? m_edges + 1 : m_edges;
      m_pend  <= (m_pend & ~m_clear()) | m_rise();
      if (m_phase == 0 && (m_pend & irq_mask) != '0) begin
        m_phase <= 1;
        m_id    <= lowest(m_pend & irq_mask);
      end else if (m_phase == 1 && interrupt_acknowledge) begin
        m_phase <= 2;
      end else if (m_phase == 2 && irq_complete) begin
        m_phase <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("model_req", {31'd0, interrupt_request}, {31'd0, m_phase == 1});
    chk("model_svc", {31'd0, in_service}, {31'd0, m_phase == 2});
    chk("model_id", {29'd0, irq_id}, m_id);
    chk("model_pend", {24'd0, irq_pending}, {24'd0, m_pend});
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !interrupt_request; k++) step();
    chk("wait_req", {31'd0, interrupt_request}, 32'd1);
  endtask

  task automatic service(input int exp_id);
    wait_req();
    chk("service_id", {29'd0, irq_id}, exp_id);
    interrupt_acknowledge = 1'b1;
    step();
    interrupt_acknowledge = 1'b0;
    chk("service_in", {31'd0, in_service}, 32'd1);
    irq_complete = 1'b1;
    step();
    irq_complete = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_req", {31'd0, interrupt_request}, 32'd0);
    chk("rst_pend", {24'd0, irq_pending}, 32'd0);
    reset_n = 1'b1;
    step();

    // Single source: pending after E0, request after E1, ack accepted at E3.
    irq_src = 8'h04;
    repeat (LAT + 1) step();
    chk("single_pend", {24'd0, irq_pending}, 32'h04);
    chk("single_noreq", {31'd0, interrupt_request}, 32'd0);
    step();
    chk("single_req", {31'd0, interrupt_request}, 32'd1);
    chk("single_id", {29'd0, irq_id}, 32'd2);
    step();
    interrupt_acknowledge = 1'b1;
    step();
    chk("ack_req", {31'd0, interrupt_request}, 32'd0);
    chk("ack_pend", {24'd0, irq_pending}, 32'd0);
    chk("ack_svc", {31'd0, in_service}, 32'd1);
    step();
    interrupt_acknowledge = 1'b0;
    chk("ack_ignored", {31'd0, in_service}, 32'd1);
    irq_complete = 1'b1;
    step();
    irq_complete = 1'b0;
    chk("complete_idle", {31'd0, in_service}, 32'd0);
    irq_src = '0;
    repeat (3) step();

    // Priority with a mask change during REQUEST.
    irq_src = 8'h62;
    wait_req();
    chk("prio_id1", {29'd0, irq_id}, 32'd1);
    irq_mask = 8'hFD;
    step();
    chk("frozen_id", {29'd0, irq_id}, 32'd1);
    chk("frozen_req", {31'd0, interrupt_request}, 32'd1);
    service(1);
    service(5);
    service(6);
    irq_mask = 8'hFF;
    irq_src = '0;
    repeat (3) step();

    // Masked source still latches; unmasking requests one cycle later.
    irq_mask = 8'hF7;
    irq_src  = 8'h08;
    repeat (LAT + 3) step();
    chk("masked_pend", {24'd0, irq_pending}, 32'h08);
    chk("masked_noreq", {31'd0, interrupt_request}, 32'd0);
    irq_mask = 8'hFF;
    step();
    chk("unmask_req", {31'd0, interrupt_request}, 32'd1);
    chk("unmask_id", {29'd0, irq_id}, 32'd3);
    service(3);
    irq_src = '0;
    repeat (3) step();

    // Collision: source 4 re-rises on its own acknowledge edge.
    irq_src = 8'h10;
    wait_req();
    irq_src = 8'h00;
    step();
    irq_src = 8'h10;
    repeat (LAT) step();
    interrupt_acknowledge = 1'b1;
    step();
    interrupt_acknowledge = 1'b0;
    chk("collide_pend", {31'd0, irq_pending[4]}, 32'd1);
    chk("collide_svc", {31'd0, in_service}, 32'd1);
    irq_complete = 1'b1;
    step();
    irq_complete = 1'b0;
    service(4);
    irq_src = '0;
    repeat (3) step();

    // One-cycle pulse is latched.
    irq_mask = 8'h00;
    irq_src  = 8'h80;
    step();
    irq_src = 8'h00;
    repeat (LAT + 2) step();
    chk("pulse_pend", {31'd0, irq_pending[7]}, 32'd1);
    irq_mask = 8'hFF;
    service(7);

    // Stray handshakes, then asynchronous reset in IN_SERVICE.
    step();
    interrupt_acknowledge = 1'b1;
    step();
    interrupt_acknowledge = 1'b0;
    chk("stray_ack", {30'd0, interrupt_request, in_service}, 32'd0);
    irq_src = 8'h01;
    wait_req();
    irq_complete = 1'b1;
    step();
    irq_complete = 1'b0;
    chk("stray_cpl_req", {31'd0, interrupt_request}, 32'd1);
    chk("stray_cpl_svc", {31'd0, in_service}, 32'd0);
    interrupt_acknowledge = 1'b1;
    step();
    interrupt_acknowledge = 1'b0;
    irq_src = 8'h21;
    step();
    reset_n = 1'b0;
    #1;
    chk("async_rst", {21'd0, interrupt_request, in_service, irq_id, irq_pending}, 32'd0);
    step();
    reset_n = 1'b1;
    repeat (LAT + 4) step();
    chk("held_src_pend", {24'd0, irq_pending}, 32'd0);
    chk("held_src_req", {31'd0, interrupt_request}, 32'd0);

    // Randomized traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) irq_src = irq_src ^ N'($urandom);
      if ($urandom_range(0, 40) == 0) irq_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : N'($urandom);
      interrupt_acknowledge = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      irq_complete = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      reset_n = !(c >= 1500 && c < 1502);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
